// File: rtl/sonar_recorder_pkg.sv
// Shared constants, header layout and FSM states for the sonar stream recorder.
package sonar_recorder_pkg;

    localparam logic [7:0] CODE_RESERVED    = 8'h00;
    localparam logic [7:0] CODE_STREAM_BEAT = 8'h01;

    localparam int HDR_CODE_LSB = 56;
    localparam int HDR_IFID_LSB = 48;
    localparam int HDR_ARGC_LSB = 40;
    localparam int HDR_DROP_BIT = 39;
    localparam int HDR_SEQ_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        META,
        TS
    } recorder_state_t;

    function automatic logic [63:0] makeHeader(
        input logic [7:0]  ifId,
        input logic [7:0]  argCount,
        input logic        dropFlag,
        input logic [31:0] seqNum
    );
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_CODE_LSB +: 8]  = CODE_STREAM_BEAT;
        hdr[HDR_IFID_LSB +: 8]  = ifId;
        hdr[HDR_ARGC_LSB +: 8]  = argCount;
        hdr[HDR_DROP_BIT]       = dropFlag;
        hdr[HDR_SEQ_LSB +: 32]  = seqNum;
        return hdr;
    endfunction

endpackage

// File: rtl/sonar_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop in the same cycle frees room for a push when full.
module sonar_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [AW:0]      used;
    logic             doRead;
    logic             doWrite;

    assign empty   = (used == '0);
    assign full    = (used == (AW+1)'(DEPTH));
    assign count   = used;
    assign rdData  = mem[rdPtr];
    assign doRead  = rdEn && !empty;
    assign doWrite = wrEn && (!full || doRead);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            used  <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + AW'(1);
            if (doRead)  rdPtr <= rdPtr + AW'(1);
            case ({doWrite, doRead})
                2'b10:   used <= used + (AW+1)'(1);
                2'b01:   used <= used - (AW+1)'(1);
                default: used <= used;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/sonar_stream_recorder.sv
// Passive AXI-Stream tap that turns every accepted beat into a header/data/meta log record.
// Optional timestamp word per record when SONAR_RECORDER_TIMESTAMP_EN is defined.
//
// state  | meaning
// IDLE   | nothing held, waiting for a captured beat
// HEADER | emitting header word of the held beat
// DATA   | emitting data words, least significant first (wordCnt counts down)
// META   | emitting tkeep/tlast word
// TS     | emitting capture timestamp (timestamp build only)
module sonar_stream_recorder
    import sonar_recorder_pkg::*;
#(
    parameter int         DATA_WIDTH   = 64,
    parameter int         LOG_WIDTH    = 64,
    parameter int         FIFO_DEPTH   = 16,
    parameter int         TS_WIDTH     = 48,
    parameter logic [7:0] INTERFACE_ID = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     mon_tdata,
    input  logic [DATA_WIDTH/8-1:0]   mon_tkeep,
    input  logic                      mon_tlast,
    input  logic                      mon_tvalid,
    input  logic                      mon_tready,
    output logic [LOG_WIDTH-1:0]      log_tdata,
    output logic                      log_tvalid,
    input  logic                      log_tready,
    output logic                      log_tlast,
    output logic [31:0]               drop_count,
    output logic                      busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int NDATA      = DATA_WIDTH / LOG_WIDTH;
    localparam int CNT_W      = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef SONAR_RECORDER_TIMESTAMP_EN
    localparam int         ENTRY_W   = DATA_WIDTH + KEEP_WIDTH + 1 + TS_WIDTH;
    localparam logic [7:0] ARG_COUNT = 8'(NDATA + 2);
`else
    localparam int         ENTRY_W   = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [7:0] ARG_COUNT = 8'(NDATA + 1);
`endif

    recorder_state_t        state, nextState;
    logic [ENTRY_W-1:0]     fifoWrData, fifoRdData, holdEntry;
    logic                   fifoFull, fifoEmpty, fifoPush;
    logic [CW-1:0]          fifoCount;
    logic [CW:0]            occupancy;
    logic [DATA_WIDTH-1:0]  holdData;
    logic [KEEP_WIDTH-1:0]  holdKeep;
    logic                   holdLast;
    logic [LOG_WIDTH-1:0]   dataWord, metaWord, wordOut;
    logic [CNT_W-1:0]       wordCnt;
    logic [31:0]            seqNum, dropCount;
    logic                   dropPending, capture, capFull, pushOk, dropBeat;
    logic                   pop, validOut, lastOut, recordDone, headerAccept, dataAccept;

`ifdef SONAR_RECORDER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]    tsCount, holdTs;

    assign fifoWrData = {mon_tdata, mon_tkeep, mon_tlast, tsCount};
    assign holdTs     = holdEntry[TS_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tsCount <= '0;
        else     tsCount <= tsCount + TS_WIDTH'(1);
    end
`else
    assign fifoWrData = {mon_tdata, mon_tkeep, mon_tlast};
`endif

    assign holdData = holdEntry[ENTRY_W-1 -: DATA_WIDTH];
    assign holdKeep = holdEntry[ENTRY_W-DATA_WIDTH-1 -: KEEP_WIDTH];
    assign holdLast = holdEntry[ENTRY_W-DATA_WIDTH-KEEP_WIDTH-1];
    assign metaWord = {holdLast, {(LOG_WIDTH-1-KEEP_WIDTH){1'b0}}, holdKeep};

    // The beat being emitted still counts against capacity until its last word is accepted.
    assign occupancy = {1'b0, fifoCount} + {{CW{1'b0}}, (state != IDLE)};
    assign capFull   = fifoFull || (occupancy >= (CW+1)'(FIFO_DEPTH));
    assign capture   = mon_tvalid && mon_tready && enable;
    assign pushOk    = !capFull || recordDone;
    assign fifoPush  = capture && pushOk;
    assign dropBeat  = capture && !pushOk;

    assign headerAccept = (state == HEADER) && log_tready;
    assign dataAccept   = (state == DATA) && log_tready;
    assign recordDone   = lastOut && log_tready;

    sonar_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (fifoPush),
        .wrData (fifoWrData),
        .rdEn   (pop),
        .rdData (fifoRdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    always_comb begin
        dataWord = '0;
        for (int i = 0; i < NDATA; i++) begin
            if (wordCnt == CNT_W'(NDATA - 1 - i)) dataWord = holdData[i*LOG_WIDTH +: LOG_WIDTH];
        end
    end

    always_comb begin
        nextState = state;
        pop       = 1'b0;
        validOut  = 1'b0;
        lastOut   = 1'b0;
        wordOut   = '0;
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    pop       = 1'b1;
                    nextState = HEADER;
                end
            end
            HEADER: begin
                validOut = 1'b1;
                wordOut  = makeHeader(INTERFACE_ID, ARG_COUNT, dropPending, seqNum);
                if (log_tready) nextState = DATA;
            end
            DATA: begin
                validOut = 1'b1;
                wordOut  = dataWord;
                if (log_tready && wordCnt == '0) nextState = META;
            end
            META: begin
                validOut = 1'b1;
                wordOut  = metaWord;
`ifdef SONAR_RECORDER_TIMESTAMP_EN
                if (log_tready) nextState = TS;
`else
                lastOut = 1'b1;
`endif
            end
`ifdef SONAR_RECORDER_TIMESTAMP_EN
            TS: begin
                validOut = 1'b1;
                lastOut  = 1'b1;
                wordOut  = LOG_WIDTH'(holdTs);
            end
`endif
            default: nextState = IDLE;
        endcase
        // Zero-bubble chaining into the next record straight from the last word.
        if (lastOut && log_tready) begin
            if (!fifoEmpty) begin
                pop       = 1'b1;
                nextState = HEADER;
            end else begin
                nextState = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            holdEntry   <= '0;
            wordCnt     <= '0;
            seqNum      <= '0;
            dropPending <= 1'b0;
            dropCount   <= '0;
        end else begin
            state <= nextState;
            if (pop) holdEntry <= fifoRdData;
            if (headerAccept) begin
                wordCnt <= CNT_W'(NDATA - 1);
                seqNum  <= seqNum + 32'd1;
            end else if (dataAccept && wordCnt != '0) begin
                wordCnt <= wordCnt - CNT_W'(1);
            end
            if (dropBeat)          dropPending <= 1'b1;
            else if (headerAccept) dropPending <= 1'b0;
            if (dropBeat && dropCount != 32'hFFFF_FFFF) dropCount <= dropCount + 32'd1;
        end
    end

    assign log_tdata  = wordOut;
    assign log_tvalid = validOut;
    assign log_tlast  = lastOut;
    assign drop_count = dropCount;
    assign busy       = !fifoEmpty || (state != IDLE);

endmodule

// File: tb/tb_sonar_stream_recorder.sv
// Directed bench for sonar_stream_recorder: record layout, drops, backpressure, reset, timestamps.
module tb_sonar_stream_recorder;

`ifdef SONAR_RECORDER_TIMESTAMP_EN
    localparam logic [7:0] ARGC      = 8'd3;
    localparam int         REC_WORDS = 4;
    localparam logic       META_LAST = 1'b0;
`else
    localparam logic [7:0] ARGC      = 8'd2;
    localparam int         REC_WORDS = 3;
    localparam logic       META_LAST = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] mon_tdata = '0;
    logic [7:0]  mon_tkeep = '0;
    logic        mon_tlast = 1'b0;
    logic        mon_tvalid = 1'b0;
    logic        mon_tready = 1'b0;
    logic [63:0] log_tdata;
    logic        log_tvalid;
    logic        log_tready = 1'b0;
    logic        log_tlast;
    logic [31:0] drop_count;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [64:0] logQ [$];
    bit          randReady = 1'b0;
    bit          chkStable = 1'b1;
    logic        prevStall = 1'b0;
    logic [63:0] prevData = '0;
    logic        prevLast = 1'b0;

    always #5 clk = ~clk;

    sonar_stream_recorder #(
        .DATA_WIDTH   (64),
        .LOG_WIDTH    (64),
        .FIFO_DEPTH   (16),
        .TS_WIDTH     (48),
        .INTERFACE_ID (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mon_tdata  (mon_tdata),
        .mon_tkeep  (mon_tkeep),
        .mon_tlast  (mon_tlast),
        .mon_tvalid (mon_tvalid),
        .mon_tready (mon_tready),
        .log_tdata  (log_tdata),
        .log_tvalid (log_tvalid),
        .log_tready (log_tready),
        .log_tlast  (log_tlast),
        .drop_count (drop_count),
        .busy       (busy)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: collect accepted words and hold stalled words to their previous value.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall && chkStable) begin
                checkVal("stallValid", 64'(log_tvalid), 64'd1);
                checkVal("stallData", log_tdata, prevData);
                checkVal("stallLast", 64'(log_tlast), 64'(prevLast));
            end
            if (log_tvalid && log_tready) logQ.push_back({log_tlast, log_tdata});
            prevStall = log_tvalid && !log_tready;
            prevData  = log_tdata;
            prevLast  = log_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (randReady) log_tready = ($urandom_range(99) >= 30);
    endtask

    task automatic sendBeat(input logic [63:0] data, input logic [7:0] keep, input logic last);
        mon_tdata  = data;
        mon_tkeep  = keep;
        mon_tlast  = last;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        tick();
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        logQ.delete();
    endtask

    task automatic waitWords(input int n);
        int k;
        k = 0;
        while (logQ.size() < n && k < 3000) begin
            tick();
            k++;
        end
        if (logQ.size() < n) checkVal("waitWords", 64'(logQ.size()), 64'(n));
    endtask

    task automatic expectRecord(input logic [31:0] seq, input logic drp, input logic [63:0] data,
                                input logic [7:0] keep, input logic last, input bit chkTs,
                                input logic [63:0] ts);
        logic [64:0] w;
        waitWords(REC_WORDS);
        if (logQ.size() < REC_WORDS) return;
        w = logQ.pop_front();
        checkVal($sformatf("hdr%0d", seq), w[63:0], {8'h01, 8'h00, ARGC, drp, 7'd0, seq});
        checkVal($sformatf("hdrLast%0d", seq), 64'(w[64]), 64'd0);
        w = logQ.pop_front();
        checkVal($sformatf("data%0d", seq), w[63:0], data);
        checkVal($sformatf("dataLast%0d", seq), 64'(w[64]), 64'd0);
        w = logQ.pop_front();
        checkVal($sformatf("meta%0d", seq), w[63:0], {last, 55'd0, keep});
        checkVal($sformatf("metaLast%0d", seq), 64'(w[64]), 64'(META_LAST));
`ifdef SONAR_RECORDER_TIMESTAMP_EN
        w = logQ.pop_front();
        if (chkTs) checkVal($sformatf("ts%0d", seq), w[63:0], ts);
        checkVal($sformatf("tsLast%0d", seq), 64'(w[64]), 64'd1);
`endif
    endtask

    initial begin
        int k;
        bit found;

        // Reset values
        log_tready = 1'b1;
        enable     = 1'b1;
        repeat (3) tick();
        checkVal("rstValid", 64'(log_tvalid), 64'd0);
        checkVal("rstLast", 64'(log_tlast), 64'd0);
        checkVal("rstData", log_tdata, 64'd0);
        checkVal("rstDrop", 64'(drop_count), 64'd0);
        checkVal("rstBusy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();

        // Single beat, header latency N+2
        sendBeat(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
        @(negedge clk);
        checkVal("t1GapValid", 64'(log_tvalid), 64'd0);
        checkVal("t1Busy", 64'(busy), 64'd1);
        @(negedge clk);
        checkVal("t1HdrValid", 64'(log_tvalid), 64'd1);
        checkVal("t1Hdr", log_tdata, {8'h01, 8'h00, ARGC, 1'b0, 7'd0, 32'd0});
        expectRecord(32'd0, 1'b0, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1, 1'b0, 64'd0);
        repeat (3) tick();

        // Capture disabled
        enable = 1'b0;
        for (int i = 0; i < 5; i++) sendBeat(64'h5500 + 64'(i), 8'h0F, 1'b1);
        repeat (6) tick();
        checkVal("en0Words", 64'(logQ.size()), 64'd0);
        checkVal("en0Drop", 64'(drop_count), 64'd0);
        checkVal("en0Busy", 64'(busy), 64'd0);
        enable = 1'b1;

        // Overflow under full stall
        doReset();
        log_tready = 1'b0;
        chkStable  = 1'b0;
        for (int i = 0; i < 20; i++) sendBeat(64'h1000 + 64'(i), 8'(i), i[0]);
        repeat (3) tick();
        checkVal("ovfDrop", 64'(drop_count), 64'd4);
        checkVal("ovfBusy", 64'(busy), 64'd1);
        checkVal("ovfWords", 64'(logQ.size()), 64'd0);
        log_tready = 1'b1;
        repeat (2) tick();
        chkStable = 1'b1;
        for (int i = 0; i < 16; i++)
            expectRecord(32'(i), (i == 0), 64'h1000 + 64'(i), 8'(i), i[0], 1'b0, 64'd0);
        repeat (3) tick();
        checkVal("ovfIdle", 64'(busy), 64'd0);

        // Random backpressure
        randReady = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sendBeat(64'hA5A5_0000_0000_0000 | 64'(i), 8'hF0 ^ 8'(i), ~i[0]);
            repeat (5) tick();
        end
        randReady  = 1'b0;
        log_tready = 1'b1;
        waitWords(100 * REC_WORDS);
        for (int i = 0; i < 100; i++)
            expectRecord(32'(16 + i), 1'b0, 64'hA5A5_0000_0000_0000 | 64'(i), 8'hF0 ^ 8'(i), ~i[0], 1'b0, 64'd0);
        checkVal("bpDrop", 64'(drop_count), 64'd4);

        // Reset during data word of the second record
        sendBeat(64'h1111_2222_3333_4444, 8'h3C, 1'b0);
        sendBeat(64'h5555_6666_7777_8888, 8'hC3, 1'b1);
        found = 1'b0;
        k = 0;
        while (!found && k < 20) begin
            @(negedge clk);
            if (log_tvalid && log_tdata == 64'h5555_6666_7777_8888) found = 1'b1;
            k++;
        end
        if (!found) checkVal("rstPoll", 64'd0, 64'd1);
        rst = 1'b1;
        #1;
        checkVal("midRstValid", 64'(log_tvalid), 64'd0);
        checkVal("midRstLast", 64'(log_tlast), 64'd0);
        checkVal("midRstData", log_tdata, 64'd0);
        checkVal("midRstDrop", 64'(drop_count), 64'd0);
        checkVal("midRstBusy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        logQ.delete();
        sendBeat(64'h0BAD_F00D_CAFE_0001, 8'h81, 1'b1);
        expectRecord(32'd0, 1'b0, 64'h0BAD_F00D_CAFE_0001, 8'h81, 1'b1, 1'b0, 64'd0);

`ifdef SONAR_RECORDER_TIMESTAMP_EN
        // Timestamps latched at ts=10 and ts=13
        rst = 1'b1;
        tick();
        rst = 1'b0;
        logQ.delete();
        repeat (10) tick();
        sendBeat(64'h0000_0000_0000_000A, 8'h01, 1'b0);
        repeat (2) tick();
        sendBeat(64'h0000_0000_0000_000D, 8'h03, 1'b1);
        expectRecord(32'd0, 1'b0, 64'h0000_0000_0000_000A, 8'h01, 1'b0, 1'b1, 64'd10);
        expectRecord(32'd1, 1'b0, 64'h0000_0000_0000_000D, 8'h03, 1'b1, 1'b1, 64'd13);
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
